cls_token_reader: RTL and testbench
===================================

Name: cls_token_reader

Overview:
- Consumer of the encoder output stream.
- Receives the n x d_model result matrix element by element, row-major, over a valid/ready interface.
- Captures row 0 (the CLS token) into a local buffer and discards rows 1..N_TOKENS-1.
- Streams the captured CLS row to the classifier MLP head over a second valid/ready interface. Emission overlaps with discarding the remaining rows.

Parameters:
- DATA_W, 8, width of one matrix element
- D_MODEL, 192, elements per token row
- N_TOKENS, 197, rows per frame (tokens+1)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-high: 1 = reset
- init  in  1  one-cycle pulse, arms reader for one frame; ignored unless ready=1
- ready  out  1  1 when idle and able to accept init
- in_valid  in  1  element valid from encoder
- in_ready  out  1  reader accepts element this cycle
- in_data  in  DATA_W  matrix element
- in_last  in  1  asserted with final element of frame
- out_valid  out  1  CLS element valid
- out_ready  in  1  head accepts element
- out_data  out  DATA_W  CLS element
- out_last  out  1  asserted with CLS element D_MODEL-1
- frame_err  out  1  sticky framing error; cleared by next accepted init

Behaviour:
- Reset values (reset_n=1 at clock edge):
  - ready=1, in_ready=0, out_valid=0, out_last=0, frame_err=0, out_data=0.
  - All counters are 0. Input FSM is IDLE and output FSM is OIDLE.
  - Asserting reset mid-frame aborts the frame. The buffer contents are don't-care afterwards.
- Transfers: a transfer occurs on any clock edge where valid & ready are both 1.
  - out_data, out_valid and out_last are registered outputs.
  - out_valid stays high and out_data stays stable until accepted.
- Counters:
  - col counts 0..D_MODEL-1. row counts 0..N_TOKENS-1.
  - Each is ceil(log2) wide, minimum 1 bit.
  - col wraps to 0 and row increments on the transfer where col=D_MODEL-1.
- Input FSM:
  - IDLE: in_ready=0. On init with ready=1, clear counters and frame_err, then go to CAPTURE.
  - CAPTURE (row 0): in_ready=1. Each transfer writes buf[col]=in_data.
    - On the col=D_MODEL-1 transfer, set cls_full and go to SKIP, or to DONE if N_TOKENS=1.
  - SKIP: in_ready=1. Transfers are discarded. The transfer with row=N_TOKENS-1 and col=D_MODEL-1 goes to DONE.
  - DONE: in_ready=0. Return to IDLE once the output FSM is OIDLE.
- in_last checking:
  - in_last=1 on any transfer other than the final element, or in_last=0 on the final element, sets frame_err.
  - Counting continues regardless. Framing is by count, never by in_last.
- Output FSM:
  - OIDLE: when cls_full=1, go to EMIT with rd_idx=0.
  - EMIT: present buf[rd_idx], with out_last=(rd_idx=D_MODEL-1).
    - Each transfer advances rd_idx.
    - The last transfer clears cls_full and out_valid and returns to OIDLE.
  - The first out_valid appears no earlier than 1 cycle after the capture of element D_MODEL-1. Latency from that capture to the first out_valid is 1 cycle.
- Concurrency:
  - EMIT runs while the input FSM is in SKIP, so out_ready back-pressure never stalls in_ready.
  - A CAPTURE write never aliases an EMIT read, because cls_full gates EMIT.
- ready=1 only when the input FSM is IDLE and the output FSM is OIDLE. init while ready=0 is ignored.
- Throughput: 1 element/cycle on each side when unstalled.

Test Plan:
- Use D_MODEL=4, N_TOKENS=3.
- Nominal frame: after reset (ready=1), send init, then elements 0x10..0x1B with in_valid=1 continuously and in_last on 0x1B, with out_ready=1.
  - out_data must be 0x10,0x11,0x12,0x13, with out_last on 0x13.
  - The first out_valid must come 1 cycle after 0x13 is accepted.
  - frame_err=0, and ready returns to 1 after both FSMs are idle.
- Output back-pressure: same frame with out_ready=0 until all 12 inputs are accepted.
  - in_ready must stay 1 for all 12 elements.
  - out_data must be held at 0x10 the whole time.
  - Releasing out_ready must emit 0x10..0x13, after which ready=1.
- Input gaps: toggle in_valid every cycle.
  - The captured row must still be exactly elements 0-3 of the stream.
  - No extra or missing out transfers: exactly 4 transfers with 1 out_last.
- Framing error: assert in_last on element 5.
  - frame_err=1 from the cycle after that transfer onward, sticky through frame end.
  - The next init clears frame_err to 0.
- Reset mid-operation: assert reset_n=1 for 1 cycle while in SKIP with out_valid=1.
  - Next cycle must show ready=1, out_valid=0, in_ready=0.
  - A fresh frame 0x20..0x2B must then emit 0x20..0x23.
- init ignored: pulse init during EMIT.
  - There must be no effect on counters or on the output sequence.

Source files
------------

// File: rtl/cls_token_reader.sv
// cls_token_reader
// Sits on the encoder output stream, keeps only row 0 (the CLS token) of each
// n x d_model result frame and replays it to the classifier head. The rest of
// the frame is drained at full rate while the CLS row is being emitted.
// Note: reset_n is active-high (1 = reset) and sampled synchronously.
module cls_token_reader #(
    parameter int DATA_W   = 8,
    parameter int D_MODEL  = 192,
    parameter int N_TOKENS = 197
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              init,
    output logic              ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_err
);

    localparam int COL_W = (D_MODEL > 1) ? $clog2(D_MODEL) : 1;
    localparam int ROW_W = (N_TOKENS > 1) ? $clog2(N_TOKENS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(D_MODEL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_TOKENS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SKIP,
        DONE
    } in_state_t;

    typedef enum logic {
        OIDLE,
        EMIT
    } out_state_t;

    in_state_t         in_state;
    in_state_t         in_state_next;
    out_state_t        out_state;
    out_state_t        out_state_next;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  rd_idx;
    logic [COL_W-1:0]  rd_next;
    logic              cls_full;
    logic [DATA_W-1:0] cls_buf [D_MODEL];

    logic              start;
    logic              in_fire;
    logic              out_fire;
    logic              col_end;
    logic              frame_end;
    logic              rd_end;
    logic              capture_end;
    logic              emit_end;

    assign ready       = (in_state == IDLE) && (out_state == OIDLE);
    assign in_ready    = (in_state == CAPTURE) || (in_state == SKIP);
    assign start       = init && ready;
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign col_end     = (col == COL_LAST);
    assign frame_end   = col_end && (row == ROW_LAST);
    assign rd_end      = (rd_idx == COL_LAST);
    assign rd_next     = rd_idx + COL_W'(1);
    assign capture_end = (in_state == CAPTURE) && in_fire && col_end;
    assign emit_end    = (out_state == EMIT) && out_fire && rd_end;

    // State registers for both the input and the output FSM
    always_ff @(posedge clk) begin
        if (reset_n) begin
            in_state  <= IDLE;
            out_state <= OIDLE;
        end else begin
            in_state  <= in_state_next;
            out_state <= out_state_next;
        end
    end

    // Input FSM: capture row 0, drain the rest, then wait for the head to finish
    always_comb begin
        in_state_next = in_state;
        unique case (in_state)
            IDLE: begin
                if (start) in_state_next = CAPTURE;
            end
            CAPTURE: begin
                if (in_fire && col_end) in_state_next = (N_TOKENS == 1) ? DONE : SKIP;
            end
            SKIP: begin
                if (in_fire && frame_end) in_state_next = DONE;
            end
            DONE: begin
                if (out_state == OIDLE && !cls_full) in_state_next = IDLE;
            end
            default: in_state_next = IDLE;
        endcase
    end

    // Output FSM: start emitting once the CLS row is complete, stop after the last element
    always_comb begin
        out_state_next = out_state;
        unique case (out_state)
            OIDLE: begin
                if (cls_full) out_state_next = EMIT;
            end
            EMIT: begin
                if (out_fire && rd_end) out_state_next = OIDLE;
            end
            default: out_state_next = OIDLE;
        endcase
    end

    // Element position within the frame; framing is by count, not by in_last
    always_ff @(posedge clk) begin
        if (reset_n || start) begin
            col <= '0;
            row <= '0;
        end else if (in_fire) begin
            if (col_end) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Sticky framing error: in_last must coincide exactly with the final element
    always_ff @(posedge clk) begin
        if (reset_n || start) begin
            frame_err <= 1'b0;
        end else if (in_fire && (in_last != frame_end)) begin
            frame_err <= 1'b1;
        end
    end

    // CLS row storage; contents are meaningless after reset so no reset term
    always_ff @(posedge clk) begin
        if (in_state == CAPTURE && in_fire) begin
            cls_buf[col] <= in_data;
        end
    end

    // cls_full hands the buffer from the writer to the reader and back
    always_ff @(posedge clk) begin
        if (reset_n) begin
            cls_full <= 1'b0;
        end else if (capture_end) begin
            cls_full <= 1'b1;
        end else if (emit_end) begin
            cls_full <= 1'b0;
        end
    end

    // Registered output stage: load element 0 on entry, advance on each accepted element
    always_ff @(posedge clk) begin
        if (reset_n) begin
            rd_idx    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (out_state == OIDLE) begin
            if (cls_full) begin
                rd_idx    <= '0;
                out_valid <= 1'b1;
                out_data  <= cls_buf[0];
                out_last  <= (D_MODEL == 1);
            end
        end else if (out_fire) begin
            if (rd_end) begin
                rd_idx    <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                rd_idx    <= rd_next;
                out_data  <= cls_buf[rd_next];
                out_last  <= (rd_next == COL_LAST);
            end
        end
    end

endmodule

// File: tb/tb_cls_token_reader.sv
// tb_cls_token_reader
// Directed frames against cls_token_reader with D_MODEL=4, N_TOKENS=3. A
// frame-level model (element counts, captured row queue, emitted count) is
// checked every cycle; per-scenario literal expectations pin the model.
module tb_cls_token_reader;

    localparam int D     = 4;
    localparam int N     = 3;
    localparam int TOTAL = D * N;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       init = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic       ready;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_err;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    bit         m_active, m_done, m_avail, m_ov, m_err;
    int         m_cnt, m_emit;
    logic [7:0] m_cls[$];

    logic [7:0] got_d[$];
    logic       got_l[$];
    int         cap_edge = -1;
    int         first_ov = -1;
    bit         p_ov, p_or, p_rst;
    logic [7:0] p_data;

    int stalls, bad_hold, hold_cyc, in_cycles;
    logic [7:0] exp_nom[4] = '{8'h10, 8'h11, 8'h12, 8'h13};

    cls_token_reader #(
        .DATA_W  (8),
        .D_MODEL (D),
        .N_TOKENS(N)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .init     (init),
        .ready    (ready),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Edge counter used for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic i_init, input logic v, input logic [7:0] d,
                                 input logic l, input logic orr);
        @(posedge clk);
        #1;
        init      = i_init;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = orr;
    endtask

    // Frame-level model: compare current outputs, then predict the state after the next edge
    always @(negedge clk) begin
        bit o_ready, o_ov, o_avail, o_done, start;
        o_ready = !m_active && !m_done && !m_ov && !m_avail;
        o_ov    = m_ov;
        o_avail = m_avail;
        o_done  = m_done;
        if (chk_en) begin
            checkOutput("ready", ready, o_ready);
            checkOutput("in_ready", in_ready, m_active);
            checkOutput("out_valid", out_valid, m_ov);
            checkOutput("frame_err", frame_err, m_err);
            if (m_ov) begin
                checkOutput("out_data", out_data, m_cls[m_emit]);
                checkOutput("out_last", out_last, m_emit == D - 1);
            end
            if (p_ov && !p_or && !p_rst) checkOutput("hold_data", out_data, p_data);
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
        end
        p_ov   = out_valid;
        p_or   = out_ready;
        p_data = out_data;
        p_rst  = reset_n;
        if (reset_n) begin
            m_active = 0; m_done = 0; m_avail = 0; m_ov = 0; m_err = 0;
            m_cnt = 0; m_emit = 0;
            m_cls.delete();
        end else begin
            start = init && o_ready;
            if (o_ov && out_ready) begin
                m_emit++;
                if (m_emit == D) m_ov = 0;
            end
            if (o_avail) begin
                m_ov = 1; m_avail = 0; m_emit = 0;
            end
            if (o_done && !o_ov && !o_avail) m_done = 0;
            if (start) begin
                m_active = 1; m_cnt = 0; m_err = 0;
                m_cls.delete();
            end else if (m_active && in_valid) begin
                if (in_last != (m_cnt == TOTAL - 1)) m_err = 1;
                if (m_cnt < D) m_cls.push_back(in_data);
                if (m_cnt == D - 1) begin
                    m_avail  = 1;
                    cap_edge = cyc + 1;
                end
                m_cnt++;
                if (m_cnt == TOTAL) begin
                    m_active = 0; m_done = 1;
                end
            end
        end
    end

    task automatic runFrame(input logic [7:0] base, input int n_in, input bit hold,
                            input bit gaps, input int err_idx, input int init_idx);
        int idx = 0;
        int c = 0;
        bit v, orr;
        got_d.delete(); got_l.delete();
        cap_edge = -1; first_ov = -1;
        stalls = 0; bad_hold = 0; hold_cyc = 0; in_cycles = 0;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk); #2;
        checkOutput("init_ready_low", ready, 0);
        checkOutput("init_clears_err", frame_err, 0);
        while ((idx < n_in || (n_in == TOTAL && got_d.size() < D)) && c < 300) begin
            v   = (idx < n_in) && (!gaps || (c % 2 == 0));
            orr = !hold || (idx >= TOTAL);
            applyStimulus(idx == init_idx, v, base + 8'(idx),
                          (idx == TOTAL - 1) || (idx == err_idx), orr);
            @(negedge clk); #2;
            if (idx < n_in) in_cycles++;
            if (v && !in_ready) stalls++;
            if (out_valid && !orr) begin
                hold_cyc++;
                if (out_data != base) bad_hold++;
            end
            if (v && in_ready) idx++;
            c++;
        end
        checkOutput("frame_timeout", c < 300, 1);
        if (n_in == TOTAL) begin
            for (int w = 0; w < 20; w++) begin
                applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
                @(negedge clk); #2;
                if (ready) break;
            end
            checkOutput("ready_return", ready, 1);
        end
    endtask

    task automatic checkSeq(input string tag, input logic [7:0] base);
        int nl = 0;
        checkOutput({tag, "_count"}, got_d.size(), D);
        for (int i = 0; i < got_d.size() && i < D; i++) begin
            checkOutput({tag, "_data"}, got_d[i], base + 8'(i));
            checkOutput({tag, "_last"}, got_l[i], i == D - 1);
        end
        foreach (got_l[i]) if (got_l[i]) nl++;
        checkOutput({tag, "_last_count"}, nl, 1);
    endtask

    initial begin
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        chk_en  = 1'b1;
        @(negedge clk); #2;
        checkOutput("rst_ready", ready, 1);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_frame_err", frame_err, 0);
        checkOutput("rst_out_data", out_data, 8'h00);

        $display("[TB] nominal frame");
        runFrame(8'h10, TOTAL, 1'b0, 1'b0, -1, -1);
        checkOutput("nom_count", got_d.size(), 4);
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            checkOutput("nom_data", got_d[i], exp_nom[i]);
            checkOutput("nom_last", got_l[i], i == 3);
        end
        checkOutput("nom_latency", first_ov - cap_edge, 1);
        checkOutput("nom_frame_err", frame_err, 0);

        $display("[TB] output back-pressure");
        runFrame(8'h10, TOTAL, 1'b1, 1'b0, -1, -1);
        checkOutput("bp_in_stalls", stalls, 0);
        checkOutput("bp_in_cycles", in_cycles, 12);
        checkOutput("bp_bad_hold", bad_hold, 0);
        checkOutput("bp_hold_cycles", hold_cyc, 7);
        checkSeq("bp", 8'h10);

        $display("[TB] input gaps");
        runFrame(8'h40, TOTAL, 1'b0, 1'b1, -1, -1);
        checkSeq("gap", 8'h40);

        $display("[TB] init during emit");
        runFrame(8'h50, TOTAL, 1'b0, 1'b0, -1, 6);
        checkSeq("ign", 8'h50);
        checkOutput("ign_frame_err", frame_err, 0);

        $display("[TB] framing error");
        runFrame(8'h60, TOTAL, 1'b0, 1'b0, 5, -1);
        checkSeq("ferr", 8'h60);
        checkOutput("ferr_sticky", frame_err, 1);

        $display("[TB] reset mid-frame");
        runFrame(8'h30, 6, 1'b1, 1'b0, -1, -1);
        checkOutput("pre_rst_out_valid", out_valid, 1);
        checkOutput("pre_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        reset_n = 1'b1; init = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk); #2;
        checkOutput("post_rst_ready", ready, 1);
        checkOutput("post_rst_out_valid", out_valid, 0);
        checkOutput("post_rst_in_ready", in_ready, 0);
        runFrame(8'h20, TOTAL, 1'b0, 1'b0, -1, -1);
        checkSeq("fresh", 8'h20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
